// File: rtl/axis_pkt_engine_if.sv
// AXI-stream bundle used by the packet engine.
// The master drives data/valid/last; the slave drives ready.
interface axis_pkt_engine_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_pkt_engine.sv
// Store-and-forward AXI-stream packet engine: buffers one packet, transforms each word in place,
// then replays it in order. Oversized packets are dropped. Statistics counters saturate.
module axis_pkt_engine #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned DEPTH         = 256,
  parameter int unsigned EOP_MARKER_EN = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  axis_pkt_engine_if.slave       s_axis,
  axis_pkt_engine_if.master      m_axis,
  input  logic [1:0]             cfg_mode,
  input  logic [DATA_W-1:0]      cfg_operand,
  output logic [CNT_W-1:0]       stat_pkt_count,
  output logic [CNT_W-1:0]       stat_drop_count,
  output logic [$clog2(DEPTH):0] stat_len,
  output logic                   busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LenFull = LW'(DEPTH);

  localparam logic [1:0] StRecv = 2'd0;
  localparam logic [1:0] StProc = 2'd1;
  localparam logic [1:0] StXmit = 2'd2;
  localparam logic [1:0] StDrop = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [LW-1:0]     len_q, len_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [LW-1:0]     rd_q, rd_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [LW-1:0]     stat_len_q, stat_len_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              s_ready;
  logic              s_beat;
  logic              marker_hit;
  logic              is_end;
  logic              m_hs;
  logic [LW-1:0]     last_idx;

  function automatic logic [DATA_W-1:0] xform(input logic [1:0]        mode,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (mode)
      2'd0:    r = a;
      2'd1:    r = a + b;
      2'd2:    r = a * b;
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign s_ready    = (state_q == StRecv) || (state_q == StDrop);
  assign s_beat     = s_axis.tvalid && s_ready;
  assign marker_hit = (EOP_MARKER_EN != 0) && (s_axis.tdata[DATA_W-1 -: 8] == 8'hFF);
  assign is_end     = s_axis.tlast || marker_hit;
  assign m_hs       = out_valid_q && m_axis.tready;
  assign last_idx   = len_q - LW'(1);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    rd_d        = rd_q;
    mode_d      = mode_q;
    op_d        = op_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    pkt_cnt_d   = pkt_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    stat_len_d  = stat_len_q;
    mem_we      = 1'b0;
    mem_waddr   = len_q[AW-1:0];
    mem_wdata   = s_axis.tdata;

    case (state_q)
      StRecv: begin
        if (s_beat) begin
          if (len_q == LenFull) begin
            // Buffer full: an end beat here already overflows, so the packet is dropped outright.
            if (is_end) begin
              drop_cnt_d = sat_inc(drop_cnt_q);
              len_d      = '0;
            end else begin
              state_d = StDrop;
            end
          end else begin
            mem_we     = 1'b1;
            len_d      = len_q + LW'(1);
            stat_len_d = len_q + LW'(1);
            if (is_end) begin
              state_d = StProc;
              mode_d  = cfg_mode;
              op_d    = cfg_operand;
              idx_d   = '0;
            end
          end
        end
      end

      StProc: begin
        mem_we    = 1'b1;
        mem_waddr = idx_q;
        mem_wdata = xform(mode_q, mem_q[idx_q], op_q);
        idx_d     = idx_q + AW'(1);
        if ({1'b0, idx_q} == last_idx) begin
          state_d = StXmit;
          idx_d   = '0;
          rd_d    = '0;
        end
      end

      StXmit: begin
        if (m_hs && out_last_q) begin
          state_d     = StRecv;
          len_d       = '0;
          rd_d        = '0;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          pkt_cnt_d   = sat_inc(pkt_cnt_q);
        end else if ((!out_valid_q || m_axis.tready) && (rd_q != len_q)) begin
          // Output register refills only when empty or being consumed, so a stall holds it.
          out_valid_d = 1'b1;
          out_data_d  = mem_q[rd_q[AW-1:0]];
          out_last_d  = (rd_q == last_idx);
          rd_d        = rd_q + LW'(1);
        end
      end

      StDrop: begin
        if (s_beat && is_end) begin
          drop_cnt_d = sat_inc(drop_cnt_q);
          len_d      = '0;
          state_d    = StRecv;
        end
      end

      default: state_d = StRecv;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRecv;
      len_q       <= '0;
      idx_q       <= '0;
      rd_q        <= '0;
      mode_q      <= 2'd0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      stat_len_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rd_q        <= rd_d;
      mode_q      <= mode_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      pkt_cnt_q   <= pkt_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      stat_len_q  <= stat_len_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign s_axis.tready   = s_ready;
  assign m_axis.tvalid   = out_valid_q;
  assign m_axis.tlast    = out_last_q;
  assign m_axis.tdata    = out_data_q;
  assign stat_pkt_count  = pkt_cnt_q;
  assign stat_drop_count = drop_cnt_q;
  assign stat_len        = stat_len_q;
  assign busy            = (state_q != StRecv);

endmodule

// File: tb/tb_axis_pkt_engine.sv
// Randomised scoreboard bench for axis_pkt_engine with a packet-level reference model.
module tb_axis_pkt_engine;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 16;
  localparam int LW    = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    cfg_mode = 2'd0;
  logic [DW-1:0] cfg_operand = '0;
  logic [CW-1:0] stat_pkt_count;
  logic [CW-1:0] stat_drop_count;
  logic [LW-1:0] stat_len;
  logic          busy;

  axis_pkt_engine_if #(.DATA_W(DW)) s_if ();
  axis_pkt_engine_if #(.DATA_W(DW)) m_if ();

  axis_pkt_engine #(
    .DATA_W       (DW),
    .DEPTH        (DEPTH),
    .EOP_MARKER_EN(1),
    .CNT_W        (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis         (s_if),
    .m_axis         (m_if),
    .cfg_mode       (cfg_mode),
    .cfg_operand    (cfg_operand),
    .stat_pkt_count (stat_pkt_count),
    .stat_drop_count(stat_drop_count),
    .stat_len       (stat_len),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_err = 0;
  beat_t         exp_q[$];
  logic [DW-1:0] cur_q[$];
  int            exp_pkts = 0;
  int            exp_drops = 0;
  int            rdy_mode = 0;
  logic          rdy_manual = 1'b1;
  logic          pat[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] xf(input logic [1:0] m, input logic [DW-1:0] a,
                                       input logic [DW-1:0] b);
    logic [63:0] p;
    case (m)
      2'd0: return a;
      2'd1: return a + b;
      2'd2: begin
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
      end
      default: return a ^ b;
    endcase
  endfunction

  // Packet-level model: collect words until tlast or marker, then either drop or queue results.
  task automatic model_beat(input logic [DW-1:0] w, input logic last, input logic [1:0] m,
                            input logic [DW-1:0] op);
    beat_t b;
    cur_q.push_back(w);
    if (last || (w[31:24] == 8'hFF)) begin
      if (cur_q.size() > DEPTH) begin
        exp_drops++;
      end else begin
        for (int i = 0; i < cur_q.size(); i++) begin
          b.d = xf(m, cur_q[i], op);
          b.l = (i == cur_q.size() - 1);
          exp_q.push_back(b);
        end
        exp_pkts++;
      end
      cur_q.delete();
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    w = $urandom;
    if (w[31:24] == 8'hFF) w[31:24] = 8'h7F;
    return w;
  endfunction

  task automatic send_pkt(input logic [DW-1:0] w[$], input bit end_tlast, input bit gaps,
                          input bit jitter_cfg);
    int t;
    for (int i = 0; i < w.size(); i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) repeat ($urandom_range(1, 3)) @(negedge clk);
      @(negedge clk);
      s_if.tdata  = w[i];
      s_if.tlast  = end_tlast && (i == w.size() - 1);
      s_if.tvalid = 1'b1;
      t = 0;
      while (!s_if.tready) begin
        @(negedge clk);
        t++;
        if (t > 5000) begin
          $display("FAIL send_timeout: s_axis_tready stuck at 0, expected 1");
          $fatal(1);
        end
      end
      @(posedge clk);
      model_beat(w[i], s_if.tlast, cfg_mode, cfg_operand);
      #2;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
    end
    if (jitter_cfg) begin
      cfg_mode    = 2'($urandom_range(0, 3));
      cfg_operand = $urandom;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (((exp_q.size() != 0) || m_if.tvalid) && (t < 3000)) begin
      @(posedge clk);
      #2;
      t++;
    end
    n_cmp++;
    if (t >= 3000) begin
      n_err++;
      $display("FAIL drain_timeout: %0d words outstanding, expected 0", exp_q.size());
    end
    repeat (2) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!m_if.tvalid && (t < 200)) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk("wait_valid", m_if.tvalid, 1);
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) begin
      m_if.tready = rdy_manual;
    end else if (rdy_mode == 1) begin
      m_if.tready = ($urandom_range(0, 2) != 0);
    end else if (pat.size() != 0) begin
      m_if.tready = pat.pop_front();
    end else begin
      m_if.tready = rdy_manual;
    end
  end

  logic          prev_stall = 1'b0;
  logic [DW:0]   prev_beat = '0;
  beat_t         e;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", m_if.tvalid, 1);
        chk("hold_beat", {m_if.tdata, m_if.tlast}, prev_beat);
      end
      if (m_if.tvalid && m_if.tready) begin
        chk("s_ready_low_in_xmit", s_if.tready, 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got 0x%0h, expected no output", m_if.tdata);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", m_if.tdata, e.d);
          chk("out_last", m_if.tlast, e.l);
        end
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_beat  = {m_if.tdata, m_if.tlast};
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] w[$];
    int            k;
    bit            mk;

    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = '0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    chk("rst_s_ready", s_if.tready, 1);
    chk("rst_m_valid", m_if.tvalid, 0);
    chk("rst_m_last", m_if.tlast, 0);
    chk("rst_m_data", m_if.tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stats", {stat_pkt_count, stat_drop_count, stat_len}, 0);

    // Add mode, latency to first output
    cfg_mode = 2'd1;
    cfg_operand = 32'd5;
    w = '{32'h10, 32'h20, 32'h30};
    send_pkt(w, 1, 0, 0);
    k = 0;
    do begin
      @(posedge clk);
      #2;
      k++;
    end while (!m_if.tvalid && (k < 50));
    chk("first_valid_latency", k, 4);
    drain();
    chk("pkt_count_t1", stat_pkt_count, exp_pkts);
    chk("stat_len_t1", stat_len, 3);

    // Multiply truncation and xor
    cfg_mode = 2'd2;
    cfg_operand = 32'h0001_0000;
    w = '{32'h0002_0000};
    send_pkt(w, 1, 0, 1);
    cfg_mode = 2'd3;
    cfg_operand = 32'hFFFF_FFFF;
    w = '{32'h0F0F_0F0F};
    send_pkt(w, 1, 0, 1);
    drain();
    chk("pkt_count_t2", stat_pkt_count, exp_pkts);
    chk("stat_len_single", stat_len, 1);

    // Back-pressure pattern on a 4-word pass packet
    cfg_mode = 2'd0;
    rdy_manual = 1'b0;
    w = '{rnd_word(), rnd_word(), rnd_word(), rnd_word()};
    send_pkt(w, 1, 0, 0);
    wait_valid();
    pat = '{1, 0, 0, 1, 0, 1, 1};
    rdy_manual = 1'b1;
    rdy_mode = 2;
    drain();
    rdy_mode = 0;

    // Overflow drop, recovery, exactly-full packet
    w.delete();
    for (int i = 0; i < 10; i++) w.push_back(rnd_word());
    send_pkt(w, 1, 0, 0);
    w = '{32'hA, 32'hB};
    send_pkt(w, 1, 0, 0);
    w.delete();
    for (int i = 0; i < DEPTH; i++) w.push_back(rnd_word());
    send_pkt(w, 1, 0, 0);
    drain();
    chk("drop_count_t4", stat_drop_count, exp_drops);
    chk("pkt_count_t4", stat_pkt_count, exp_pkts);
    chk("stat_len_full", stat_len, DEPTH);

    // Legacy end marker without tlast
    w = '{32'h0000_0001, 32'hFF00_0002};
    send_pkt(w, 0, 0, 0);
    drain();
    chk("stat_len_marker", stat_len, 2);

    // Reset mid-transmit after the first of three words
    rdy_manual = 1'b0;
    w = '{rnd_word(), rnd_word(), rnd_word()};
    send_pkt(w, 1, 0, 0);
    wait_valid();
    pat = '{1};
    rdy_mode = 2;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    cur_q.delete();
    exp_pkts = 0;
    exp_drops = 0;
    @(posedge clk);
    #2;
    chk("rst_mid_m_valid", m_if.tvalid, 0);
    chk("rst_mid_s_ready", s_if.tready, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_stats", {stat_pkt_count, stat_drop_count, stat_len}, 0);
    rst = 1'b0;
    rdy_mode = 0;
    rdy_manual = 1'b1;
    cfg_mode = 2'd1;
    cfg_operand = $urandom;
    w = '{rnd_word(), rnd_word()};
    send_pkt(w, 1, 0, 1);
    drain();
    chk("pkt_count_after_rst", stat_pkt_count, exp_pkts);

    // Random packets with random back-pressure, gaps and cfg noise during processing
    rdy_mode = 1;
    for (int p = 0; p < 40; p++) begin
      w.delete();
      k = $urandom_range(1, 10);
      for (int i = 0; i < k; i++) w.push_back(rnd_word());
      mk = ($urandom_range(0, 5) == 0);
      if (mk) w[k-1][31:24] = 8'hFF;
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_operand = $urandom;
      send_pkt(w, !mk, 1, 1);
    end
    drain();
    chk("pkt_count_final", stat_pkt_count, exp_pkts);
    chk("drop_count_final", stat_drop_count, exp_drops);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
